// File: rtl/press_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : press_pkg
//  Description : Shared types and event codes for the push-button decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package press_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } state_e;

    // Event codes shared with a downstream event FIFO.
    typedef logic [1:0] evt_t;
    localparam evt_t EVT_NONE   = 2'd0;
    localparam evt_t EVT_SHORT  = 2'd1;
    localparam evt_t EVT_LONG   = 2'd2;
    localparam evt_t EVT_DOUBLE = 2'd3;

    localparam int unsigned PRESS_COUNT_W = 8;

    function automatic logic evt_is_pulse(input evt_t evt);
        return evt != EVT_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/press_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : press_decoder_if
//  Description : Button level in, classified event pulses / count out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface press_decoder_if;
    import press_pkg::*;

    logic                     in_db;
    logic                     short_press;
    logic                     long_press;
    logic                     double_press;
    logic                     held;
    logic [PRESS_COUNT_W-1:0] press_count;

    modport master (
        output in_db,
        input  short_press,
        input  long_press,
        input  double_press,
        input  held,
        input  press_count
    );

    modport slave (
        input  in_db,
        output short_press,
        output long_press,
        output double_press,
        output held,
        output press_count
    );

endinterface
`default_nettype wire

// File: rtl/press_decoder_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : edge_detect
//  Description : One-cycle delayed copy of a level with rise/fall strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic level_i,
    output logic      rise_o,
    output logic      fall_o
);

    logic level_q;

    // Resetting to 1 means a level held high through reset is never a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= RST_VAL;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;
    assign fall_o = ~level_i & level_q;

endmodule
`default_nettype wire

// File: rtl/press_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : press_decoder
//  Description : Classifies debounced button activity into short/long/double.
//  Revision    : 1.0 - initial release
// ============================================================================
module press_decoder
    import press_pkg::*;
#(
    parameter int LONG_CYCLES = 1000,
    parameter int DBL_GAP     = 500,
    parameter int CNT_W       = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    press_decoder_if.slave   btn_if
);

    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(DBL_GAP - 1);

    logic w_rise;
    logic w_fall;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         timer_q, timer_d;
    evt_t                     evt_d;
    logic                     short_q, long_q, double_q, held_q;
    logic [PRESS_COUNT_W-1:0] count_q;

    edge_detect #(
        .RST_VAL (1'b1)
    ) u_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (btn_if.in_db),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        evt_d   = EVT_NONE;
        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    state_d = ST_PRESSED;
                    timer_d = '0;
                end
            end
            ST_PRESSED: begin
                // A release on the threshold cycle still counts as short.
                if (w_fall) begin
                    state_d = ST_WAIT_SECOND;
                    timer_d = '0;
                end else if (timer_q == c_LONG_LAST) begin
                    state_d = ST_LONG_HELD;
                    timer_d = '0;
                    evt_d   = EVT_LONG;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (w_fall) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            ST_WAIT_SECOND: begin
                // A second press on the expiry cycle still counts as double.
                if (w_rise) begin
                    state_d = ST_SECOND_PRESSED;
                    timer_d = '0;
                    evt_d   = EVT_DOUBLE;
                end else if (timer_q == c_GAP_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    evt_d   = EVT_SHORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SECOND_PRESSED: begin
                if (w_fall) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            short_q  <= (evt_d == EVT_SHORT);
            long_q   <= (evt_d == EVT_LONG);
            double_q <= (evt_d == EVT_DOUBLE);
            held_q   <= (state_d == ST_LONG_HELD);
            if (evt_is_pulse(evt_d)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign btn_if.short_press  = short_q;
    assign btn_if.long_press   = long_q;
    assign btn_if.double_press = double_q;
    assign btn_if.held         = held_q;
    assign btn_if.press_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_press_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_press_decoder
//  Description : Directed self-checking bench for press_decoder (L=8, G=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_press_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    press_decoder_if bus ();

    press_decoder #(
        .LONG_CYCLES (8),
        .DBL_GAP     (4),
        .CNT_W       (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_if (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Edge index: the n-th rising edge has index n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled 1 time unit after each rising edge.
    int n_short = 0, n_long = 0, n_dbl = 0, n_multi = 0, n_held = 0;
    int t_short = -1, t_long = -1, t_dbl = -1, t_hr = -1, t_hf = -1;
    logic held_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bus.short_press)  begin n_short++; t_short = cyc; end
        if (bus.long_press)   begin n_long++;  t_long  = cyc; end
        if (bus.double_press) begin n_dbl++;   t_dbl   = cyc; end
        if ((int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_press)) > 1) n_multi++;
        if (bus.held) n_held++;
        if (bus.held && !held_prev) t_hr = cyc;
        if (!bus.held && held_prev) t_hf = cyc;
        held_prev = bus.held;
    end

    int b_short, b_long, b_dbl, b_held;
    int k, r, s, exp_count;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.in_db = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_short = n_short;
        b_long  = n_long;
        b_dbl   = n_dbl;
        b_held  = n_held;
    endtask

    initial begin
        bus.in_db = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_short",  int'(bus.short_press),  0);
        chk("reset_long",   int'(bus.long_press),   0);
        chk("reset_double", int'(bus.double_press), 0);
        chk("reset_held",   int'(bus.held),         0);
        chk("reset_count",  int'(bus.press_count),  0);
        rst = 1'b0;
        exp_count = 0;
        hold(0, 3);

        // Short press: high 3, low 10.
        snap();
        hold(1, 3);
        r = cyc + 1;
        hold(0, 10);
        exp_count++;
        chk("short_n",      n_short - b_short, 1);
        chk("short_time",   t_short, r + 4);
        chk("short_nlong",  n_long - b_long, 0);
        chk("short_ndbl",   n_dbl - b_dbl, 0);
        chk("short_count",  int'(bus.press_count), exp_count);

        // Long press: high 12.
        snap();
        k = cyc + 1;
        hold(1, 12);
        r = cyc + 1;
        hold(0, 4);
        exp_count++;
        chk("long_n",       n_long - b_long, 1);
        chk("long_time",    t_long, k + 8);
        chk("long_held_up", t_hr, k + 8);
        chk("long_held_dn", t_hf, r);
        chk("long_held_n",  n_held - b_held, r - (k + 8));
        chk("long_nshort",  n_short - b_short, 0);
        chk("long_count",   int'(bus.press_count), exp_count);

        // Double press: high 2, low 2, high 5, low.
        snap();
        hold(1, 2);
        hold(0, 2);
        s = cyc + 1;
        hold(1, 5);
        hold(0, 8);
        exp_count++;
        chk("dbl_n",        n_dbl - b_dbl, 1);
        chk("dbl_time",     t_dbl, s);
        chk("dbl_nshort",   n_short - b_short, 0);
        chk("dbl_nlong",    n_long - b_long, 0);
        chk("dbl_count",    int'(bus.press_count), exp_count);

        // Release on the long threshold cycle: short wins.
        snap();
        hold(1, 8);
        r = cyc + 1;
        hold(0, 8);
        exp_count++;
        chk("bnd_long_short", n_short - b_short, 1);
        chk("bnd_long_nlong", n_long - b_long, 0);
        chk("bnd_long_time",  t_short, r + 4);
        chk("bnd_long_count", int'(bus.press_count), exp_count);

        // Second press on the gap-expiry cycle, then a long hold: only double.
        snap();
        hold(1, 2);
        r = cyc + 1;
        hold(0, 4);
        s = cyc + 1;
        hold(1, 12);
        hold(0, 8);
        exp_count++;
        chk("bnd_dbl_n",      n_dbl - b_dbl, 1);
        chk("bnd_dbl_time",   t_dbl, r + 4);
        chk("bnd_dbl_nshort", n_short - b_short, 0);
        chk("bnd_dbl_nlong",  n_long - b_long, 0);
        chk("bnd_dbl_count",  int'(bus.press_count), exp_count);

        // Reset while waiting for a second press.
        snap();
        hold(1, 2);
        hold(0, 2);
        rst = 1'b1;
        hold(0, 2);
        rst = 1'b0;
        hold(0, 10);
        exp_count = 0;
        chk("rst_wait_pulses", (n_short - b_short) + (n_long - b_long) + (n_dbl - b_dbl), 0);
        chk("rst_wait_count",  int'(bus.press_count), exp_count);

        // Button held through reset release.
        bus.in_db = 1'b1;
        rst = 1'b1;
        hold(1, 3);
        rst = 1'b0;
        snap();
        hold(1, 12);
        chk("rst_held_pulses", (n_short - b_short) + (n_long - b_long) + (n_dbl - b_dbl), 0);
        chk("rst_held_held",   n_held - b_held, 0);
        hold(0, 2);
        hold(1, 3);
        r = cyc + 1;
        hold(0, 8);
        exp_count++;
        chk("rst_held_short",  n_short - b_short, 1);
        chk("rst_held_time",   t_short, r + 4);
        chk("rst_held_count",  int'(bus.press_count), exp_count);

        // Counter wrap.
        rst = 1'b1;
        hold(0, 2);
        rst = 1'b0;
        hold(0, 2);
        snap();
        for (int i = 0; i < 255; i++) begin
            hold(1, 2);
            hold(0, 6);
        end
        chk("wrap_count_255", int'(bus.press_count), 255);
        hold(1, 2);
        hold(0, 6);
        chk("wrap_count_0",   int'(bus.press_count), 0);
        chk("wrap_nshort",    n_short - b_short, 256);
        chk("wrap_nother",    (n_long - b_long) + (n_dbl - b_dbl), 0);

        chk("one_pulse_max",  n_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/press_decoder.md
# press_decoder

Classifies debounced push-button activity into discrete user events: short press, long press and double press. Sits directly downstream of the input debouncer and consumes its stable level output. Emits registered single-cycle event pulses, a held-level flag and a wrapping event counter for the control logic above it.

## Interface
- `LONG_CYCLES`, default 1000: hold time in clk cycles that classifies a press as long; legal range 2..2^CNT_W-1.
- `DBL_GAP`, default 500: maximum release-to-second-press gap, in cycles, for a double press; legal range 2..2^CNT_W-1.
- `CNT_W`, default 16: width of the internal timer.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_db` in 1: debounced button level; 1 means pressed.
- `short_press` out 1: one-cycle pulse, short press recognised.
- `long_press` out 1: one-cycle pulse, long hold recognised.
- `double_press` out 1: one-cycle pulse, second press arrived within the gap.
- `held` out 1: high while a long press is still being held.
- `press_count` out 8: number of events recognised (any pulse); wraps from 255 to 0.

## Operation
- The block keeps `in_d`, a one-cycle-delayed copy of `in_db`.
  - rise = `in_db & ~in_d`.
  - fall = `~in_db & in_d`.
- FSM states and transitions:
  - IDLE: on rise, go to PRESSED and set timer to 0.
  - PRESSED: timer increments each cycle.
    - On fall, go to WAIT_SECOND and set timer to 0.
    - Otherwise, when timer == LONG_CYCLES-1, go to LONG_HELD and pulse `long_press`.
  - LONG_HELD: `held`=1. On fall, go to IDLE.
  - WAIT_SECOND: timer increments each cycle.
    - On rise, go to SECOND_PRESSED and pulse `double_press`.
    - Otherwise, when timer == DBL_GAP-1, go to IDLE and pulse `short_press`.
  - SECOND_PRESSED: waits for fall, then goes to IDLE. No further event is produced, however long the hold lasts.
- At most one pulse is asserted in any cycle.
- `press_count` increments by 1 in the same cycle that any pulse is asserted.
- The timer never wraps; it is cleared on every state entry.
- Simultaneous-event rules:
  - In PRESSED, fall on the threshold cycle: fall wins. The press is treated as short and `long_press` is not emitted.
  - In WAIT_SECOND, rise on the gap-expiry cycle: rise wins and `double_press` is emitted, not `short_press`.
- Reset values:
  - State IDLE, timer 0.
  - `in_d`=1, so a button held through reset must be released before any press is recognised.
  - All outputs 0, `press_count`=0.
- Reset asserted mid-operation abandons the current event: no pulse is emitted and the count is not changed.

## Timing
- All outputs are registered.
- Pulses appear in the cycle after the edge at which the FSM decides.
- Press with `in_db` first high at edge k:
  - PRESSED is entered at edge k.
  - `long_press` is high during cycle k+LONG_CYCLES, i.e. after the edge where timer reaches LONG_CYCLES-1.
  - `held` rises in that same cycle.
- Release first seen at edge r:
  - After a long press, `held` falls the cycle after r.
  - After a short press, `short_press` is high DBL_GAP cycles after r, provided no second press arrives.
- `double_press` is high the cycle after the edge that first sees the second high level.

## Structure
- Shared package `press_pkg`:
  - State enum: IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED.
  - Event-code constants, for reuse by a downstream event FIFO.
- Sub-module `edge_detect`:
  - Holds the `in_d` register (reset value parameterised, here 1).
  - Outputs `rise` and `fall`.
- The FSM, timer and counter live in `press_decoder`.

## Test plan
Benches run with LONG_CYCLES=8 and DBL_GAP=4.
- Short press: `in_db` high for 3 cycles, then low for 10 cycles → `short_press` pulses exactly once, 4 cycles after release. `press_count`=1, no other pulses.
- Long press: `in_db` high for 12 cycles → `long_press` pulses 8 cycles after press. `held` is high from that cycle until 1 cycle after release. `press_count`=1.
- Double press: high 2, low 2, high 5, low → `double_press` pulses 1 cycle after the second rise. No `short_press`, `press_count`=1.
- Boundaries:
  - Release exactly on the 8th high cycle → `short_press`, no `long_press`.
  - Second press exactly on the 4th low cycle → `double_press`, no `short_press`.
- Reset cases:
  - `in_db`=1 held through and after `rst` deassertion → no event until a low then high sequence occurs.
  - `rst` pulsed in WAIT_SECOND → no pulse and `press_count`=0.
- Counter wrap: 256 short presses → `press_count` returns to 0. Exactly one pulse is observed per press.
